// File: rtl/mux_pkg.sv
// Shared constants for the registered 4:1 mux used in the PWM / LED-dimmer path.
// Holds the default data width and the select code encoding.
package mux_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] SEL_IN1 = 2'b00;
  localparam logic [1:0] SEL_IN2 = 2'b01;
  localparam logic [1:0] SEL_IN3 = 2'b10;
  localparam logic [1:0] SEL_IN4 = 2'b11;

endpackage

// File: rtl/mux4_1_comb.sv
// Purely combinational 4:1 selector, WIDTH bits per source.
// Ports: input1..input4 (data), select (code), y (selected data).
module mux4_1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [WIDTH-1:0] input3,
  input  logic [WIDTH-1:0] input4,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] y
);

  // All four codes are legal, so the case is full without a default.
  always_comb begin
    y = input1;
    unique case (select)
      SEL_IN1: y = input1;
      SEL_IN2: y = input2;
      SEL_IN3: y = input3;
      SEL_IN4: y = input4;
    endcase
  end

endmodule

// File: rtl/mux4_1.sv
// Registered 4:1 mux choosing a PWM duty / brightness level.
// Ports: clk, rst (sync, active-high), en, input1..4, select -> selected_out, sel_q, out_valid.
module mux4_1
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [WIDTH-1:0] input3,
  input  logic [WIDTH-1:0] input4,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] selected_out,
  output logic [1:0]       sel_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] mux_y;

  logic [WIDTH-1:0] out_d, out_q;
  logic [1:0]       code_d, code_q;
  logic             valid_d, valid_q;

  mux4_1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .input1 (input1),
    .input2 (input2),
    .input3 (input3),
    .input4 (input4),
    .select (select),
    .y      (mux_y)
  );

  // Hold by default; a load captures data and the code that chose it.
  always_comb begin
    out_d   = out_q;
    code_d  = code_q;
    valid_d = valid_q;
    if (en) begin
      out_d   = mux_y;
      code_d  = select;
      valid_d = 1'b1;
    end
  end

  // Reset wins over en on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      code_q  <= SEL_IN1;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign selected_out = out_q;
  assign sel_q        = code_q;
  assign out_valid    = valid_q;

endmodule

// File: tb/tb_mux4_1.sv
// Directed + random scoreboard bench for mux4_1 at WIDTH 4 and WIDTH 8.
// Both instances share control; expectations come from a bench-side model.
module tb_mux4_1;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] select;
  logic [3:0] a1, a2, a3, a4;
  logic [7:0] b1, b2, b3, b4;

  logic [3:0] o4;
  logic [1:0] s4;
  logic       v4;
  logic [7:0] o8;
  logic [1:0] s8;
  logic       v8;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] o4;
    logic [7:0] o8;
    logic [1:0] sel;
    logic       v;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m4;
  logic [7:0] m8;
  logic [1:0] msel;
  logic       mv;

  always #5 clk = ~clk;

  mux4_1 #(.WIDTH(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .input1       (a1),
    .input2       (a2),
    .input3       (a3),
    .input4       (a4),
    .select       (select),
    .selected_out (o4),
    .sel_q        (s4),
    .out_valid    (v4)
  );

  mux4_1 #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .input1       (b1),
    .input2       (b2),
    .input3       (b3),
    .input4       (b4),
    .select       (select),
    .selected_out (o8),
    .sel_q        (s8),
    .out_valid    (v8)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, update the model, push the expectation,
  // then pop and compare just after the edge.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [1:0] s);
    exp_t x;
    rst = r;
    en = e;
    select = s;
    if (r) begin
      m4 = '0; m8 = '0; msel = 2'b00; mv = 1'b0;
    end else if (e) begin
      case (s)
        2'd0: begin m4 = a1; m8 = b1; end
        2'd1: begin m4 = a2; m8 = b2; end
        2'd2: begin m4 = a3; m8 = b3; end
        default: begin m4 = a4; m8 = b4; end
      endcase
      msel = s;
      mv = 1'b1;
    end
    sb.push_back('{o4: m4, o8: m8, sel: msel, v: mv});
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk({tag, "_out4"}, {28'd0, o4}, {28'd0, x.o4});
      chk({tag, "_out8"}, {24'd0, o8}, {24'd0, x.o8});
      chk({tag, "_sel4"}, {30'd0, s4}, {30'd0, x.sel});
      chk({tag, "_sel8"}, {30'd0, s8}, {30'd0, x.sel});
      chk({tag, "_vld4"}, {31'd0, v4}, {31'd0, x.v});
      chk({tag, "_vld8"}, {31'd0, v8}, {31'd0, x.v});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; select = 2'b00;
    a1 = '0; a2 = '0; a3 = '0; a4 = '0;
    b1 = '0; b2 = '0; b3 = '0; b4 = '0;
    m4 = '0; m8 = '0; msel = '0; mv = 1'b0;

    step("rst0", 1'b1, 1'b0, 2'b00);
    step("rst1", 1'b1, 1'b0, 2'b00);

    a1 = 4'b1000; a2 = 4'b0100; a3 = 4'b0010; a4 = 4'b0001;
    b1 = 8'hA5; b2 = 8'h5A; b3 = 8'hFF; b4 = 8'h00;
    step("sw00", 1'b0, 1'b1, 2'b00);
    step("sw01", 1'b0, 1'b1, 2'b01);
    step("sw10", 1'b0, 1'b1, 2'b10);
    step("sw11", 1'b0, 1'b1, 2'b11);

    step("ld01", 1'b0, 1'b1, 2'b01);
    a2 = 4'b1111; b2 = 8'h3C;
    step("hold0", 1'b0, 1'b0, 2'b11);
    step("hold1", 1'b0, 1'b0, 2'b11);
    step("rel", 1'b0, 1'b1, 2'b01);

    step("rstpri", 1'b1, 1'b1, 2'b11);
    step("postrst", 1'b0, 1'b1, 2'b11);

    a1 = 4'b0000; b1 = 8'h00;
    step("pre10", 1'b0, 1'b1, 2'b10);
    a1 = 4'b1010; b1 = 8'hC3;
    step("simul", 1'b0, 1'b1, 2'b00);

    for (int i = 0; i < 40; i++) begin
      a1 = 4'($urandom); a2 = 4'($urandom);
      a3 = 4'($urandom); a4 = 4'($urandom);
      b1 = 8'($urandom); b2 = 8'($urandom);
      b3 = 8'($urandom); b4 = 8'($urandom);
      step("rnd", ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom));
    end

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
